// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column drive, debounces press and release
// on the synchronized rows, and strobes new_key with a one-hot code for each accepted press.
module keypad_scanner #(
    parameter int SCAN_DIV        = 4096,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic        new_key,
    output logic [15:0] key_pressed_value
);

    localparam int SCAN_W = $clog2(SCAN_DIV) + 1;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [1:0]          cand_row_q, cand_row_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic [3:0]          row_meta_q, row_s_q;
    logic                new_key_q, new_key_d;
    logic [15:0]         key_q, key_d;

    logic                one_low;
    logic [1:0]          low_idx;
    logic [3:0]          cand_pattern;
    logic [DB_W-1:0]     db_cnt_inc;
    logic [SCAN_W-1:0]   scan_cnt_inc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= SCAN;
            col_idx_q  <= 2'd0;
            cand_row_q <= 2'd0;
            scan_cnt_q <= '0;
            db_cnt_q   <= '0;
            row_meta_q <= 4'b1111;
            row_s_q    <= 4'b1111;
            new_key_q  <= 1'b0;
            key_q      <= 16'h0000;
        end else begin
            state_q    <= state_d;
            col_idx_q  <= col_idx_d;
            cand_row_q <= cand_row_d;
            scan_cnt_q <= scan_cnt_d;
            db_cnt_q   <= db_cnt_d;
            row_meta_q <= row;
            row_s_q    <= row_meta_q;
            new_key_q  <= new_key_d;
            key_q      <= key_d;
        end
    end

    // A candidate key exists only when exactly one synchronized row is pulled low.
    always_comb begin
        one_low = 1'b1;
        low_idx = 2'd0;
        case (row_s_q)
            4'b1110: low_idx = 2'd0;
            4'b1101: low_idx = 2'd1;
            4'b1011: low_idx = 2'd2;
            4'b0111: low_idx = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    always_comb begin
        cand_pattern = ~(4'b0001 << cand_row_q);
        db_cnt_inc   = (db_cnt_q == '1) ? db_cnt_q : db_cnt_q + 1'b1;
        scan_cnt_inc = (scan_cnt_q == '1) ? scan_cnt_q : scan_cnt_q + 1'b1;

        state_d    = state_q;
        col_idx_d  = col_idx_q;
        cand_row_d = cand_row_q;
        scan_cnt_d = scan_cnt_q;
        db_cnt_d   = db_cnt_q;
        new_key_d  = 1'b0;
        key_d      = key_q;

        case (state_q)
            SCAN: begin
                if (scan_cnt_q >= SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (one_low) begin
                        cand_row_d = low_idx;
                        db_cnt_d   = '0;
                        state_d    = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_inc;
                end
            end
            DEBOUNCE: begin
                if (row_s_q != cand_pattern) begin
                    col_idx_d  = col_idx_q + 2'd1;
                    scan_cnt_d = '0;
                    state_d    = SCAN;
                end else if (db_cnt_q >= DB_LAST) begin
                    new_key_d = 1'b1;
                    key_d     = 16'h0001 << {cand_row_q, col_idx_q};
                    state_d   = HELD;
                end else begin
                    db_cnt_d = db_cnt_inc;
                end
            end
            HELD: begin
                if (row_s_q[cand_row_q]) begin
                    db_cnt_d = '0;
                    state_d  = RELEASE;
                end
            end
            RELEASE: begin
                // Any low cycle goes back to HELD so release bounce never restarts a press.
                if (!row_s_q[cand_row_q]) begin
                    state_d = HELD;
                end else if (db_cnt_q >= DB_LAST) begin
                    col_idx_d  = col_idx_q + 2'd1;
                    scan_cnt_d = '0;
                    state_d    = SCAN;
                end else begin
                    db_cnt_d = db_cnt_inc;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        col               = ~(4'b0001 << col_idx_q);
        new_key           = new_key_q;
        key_pressed_value = key_q;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: models the key matrix, queues expected key codes
// as presses are issued and pops them in a monitor whenever new_key strobes.
module tb_keypad_scanner;

    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam int TIMEOUT         = 60;
    localparam int MAX_LATENCY     = 2 + 4 * SCAN_DIV + DEBOUNCE_CYCLES + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        new_key;
    logic [15:0] key_pressed_value;

    logic [15:0] pressed = 16'h0000;
    logic [15:0] exp_q[$];
    logic [15:0] exp_val;
    int          vectors = 0;
    int          miscompares = 0;

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .row(row),
        .col(col),
        .new_key(new_key),
        .key_pressed_value(key_pressed_value)
    );

    always #5 clk = ~clk;

    // A row reads low when a pressed key in it sits on the currently driven column.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[4*r+c] && !col[c]) row[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (reset && new_key) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_strobe: actual strobe with value=%h, required no strobe",
                         key_pressed_value);
            end else begin
                exp_val = exp_q.pop_front();
                if (key_pressed_value !== exp_val) begin
                    miscompares++;
                    $display("[TB] FAIL strobe_value: actual=%h required=%h", key_pressed_value, exp_val);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] keys, input int cycles);
        pressed = keys;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic waitStrobe(input string name, output int lat);
        bit found;
        found = 1'b0;
        lat = 0;
        for (int i = 1; i <= TIMEOUT && !found; i++) begin
            @(negedge clk);
            if (new_key) begin
                found = 1'b1;
                lat = i;
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s_timeout: actual no strobe in %0d cycles, required a strobe", name, TIMEOUT);
        end
    endtask

    initial begin
        int lat;
        int bad;
        logic [3:0] one;
        logic [3:0] exp_col;

        // Reset values and the free-running column walk
        reset = 1'b0;
        pressed = 16'h0000;
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_col", 16'(col), 16'h000e);
            checkOutput("reset_new_key", 16'(new_key), 16'h0000);
            checkOutput("reset_value", key_pressed_value, 16'h0000);
        end
        reset = 1'b1;
        one = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            if (k != 0) @(negedge clk);
            exp_col = ~(one << ((k / 4) % 4));
            checkOutput("scan_col", 16'(col), 16'(exp_col));
        end

        // Clean press of (row1,col2) held for 200 cycles
        pressed = 16'h0040;
        exp_q.push_back(16'h0040);
        waitStrobe("clean_press", lat);
        checkOutput("press_latency_in_bound", 16'((lat > 0 && lat <= MAX_LATENCY) ? 1 : 0), 16'h0001);
        bad = 0;
        for (int i = 0; i < 190; i++) begin
            @(negedge clk);
            if (col !== 4'b1011) bad++;
        end
        checkOutput("held_col_frozen", 16'(bad), 16'h0000);
        applyStimulus(16'h0000, 30);

        // Press bounce on (row3,col0), then a stable press
        for (int i = 0; i < 10; i++) applyStimulus((i % 2 == 0) ? 16'h1000 : 16'h0000, 3);
        pressed = 16'h1000;
        exp_q.push_back(16'h1000);
        waitStrobe("bounced_press", lat);
        applyStimulus(16'h1000, 20);
        applyStimulus(16'h0000, 30);

        // Release bounce on (row0,col1), then a fresh press of (row2,col3)
        pressed = 16'h0002;
        exp_q.push_back(16'h0002);
        waitStrobe("release_bounce_press", lat);
        applyStimulus(16'h0002, 20);
        for (int i = 0; i < 6; i++) applyStimulus((i % 2 == 0) ? 16'h0000 : 16'h0002, 5);
        applyStimulus(16'h0000, 20);
        checkOutput("value_after_release_bounce", key_pressed_value, 16'h0002);
        pressed = 16'h0800;
        exp_q.push_back(16'h0800);
        waitStrobe("repress", lat);
        checkOutput("value_after_repress", key_pressed_value, 16'h0800);
        applyStimulus(16'h0800, 10);
        applyStimulus(16'h0000, 30);

        // Second key while held, then two keys pressed together from idle
        pressed = 16'h0020;
        exp_q.push_back(16'h0020);
        waitStrobe("first_of_two", lat);
        applyStimulus(16'h0220, 40);
        checkOutput("value_second_key_ignored", key_pressed_value, 16'h0020);
        applyStimulus(16'h0000, 30);
        applyStimulus(16'h0220, 60);
        checkOutput("value_two_keys_ignored", key_pressed_value, 16'h0020);
        applyStimulus(16'h0000, 30);

        // Reset in the middle of a debounce
        reset = 1'b0;
        pressed = 16'h0001;
        @(negedge clk);
        reset = 1'b1;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        pressed = 16'h0000;
        @(negedge clk);
        checkOutput("midreset_new_key", 16'(new_key), 16'h0000);
        checkOutput("midreset_value", key_pressed_value, 16'h0000);
        checkOutput("midreset_col", 16'(col), 16'h000e);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(16'h0000, 30);
        checkOutput("value_after_midreset", key_pressed_value, 16'h0000);

        checkOutput("pending_strobes", 16'(exp_q.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
